sr_latch_driver: RTL and testbench
==================================

# sr_latch_driver

Clocked command-side controller for the asynchronous SR latch circuit (ports S, R, Q, Qbar). It accepts set/reset commands over a valid/ready handshake and drives glitch-free, mutually exclusive S/R pulses of programmable width. It synchronises the latch's Q/Qbar feedback and returns a completion response with pass/fail status. It sits between synchronous control logic and the latch instance in the same top level.

## Interface
- PULSE_W, 2: cycles S or R is held high per command; legal range 1..15.
- TIMEOUT, 8: maximum SETTLE cycles waiting for feedback to match; legal range 1..255.
- clock  in  1  system clock, rising edge.
- reset_n  in  1  reset; asynchronous assert, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_set  in  1  1 = set the latch (target Q=1), 0 = reset it (target Q=0).
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_err  out  1  1 = feedback did not reach the target before timeout.
- rsp_q  out  1  synchronised Q value at response time.
- S  out  1  latch set drive, registered.
- R  out  1  latch reset drive, registered.
- Q  in  1  latch output, asynchronous.
- Qbar  in  1  latch complementary output, asynchronous.

## Operation
- Reset values: S=0, R=0, rsp_valid=0, rsp_err=0, rsp_q=0, cmd_ready=1 (state IDLE), synchroniser outputs q_s=0, qb_s=1.
- Q and Qbar each pass through a 2-flop synchroniser to produce q_s and qb_s. Only q_s and qb_s are used internally.
- Match condition: q_s==target and qb_s==~target. If Q==Qbar, the condition never matches and the command ends in timeout.
- States:
  - IDLE: on cmd_valid&&cmd_ready, latch target=cmd_set and go to PULSE.
  - PULSE: S=target, R=~target, held for PULSE_W cycles, then go to SETTLE.
  - SETTLE: S=R=0. Counter runs from 0. On match, go to RESP with err=0. If TIMEOUT cycles elapse without a match, go to RESP with err=1.
  - RESP: rsp_valid=1. rsp_err and rsp_q are captured on entry and held stable. On rsp_ready, go to IDLE.
- Invariants:
  - S&R is never 1.
  - S and R are high only in PULSE.
  - At most one command is in flight; cmd_valid outside IDLE is ignored.
- Reset mid-operation: S and R drop asynchronously, state returns to IDLE, the in-flight command is discarded, and no response is issued.

## Timing
- Acceptance edge = cycle 0.
- S or R is high during cycles 1..PULSE_W.
- SETTLE begins in cycle PULSE_W+1.
- Latch responding immediately gives rsp_valid at cycle max(PULSE_W,2)+2, limited by synchroniser latency.
- Timeout gives rsp_valid at cycle PULSE_W+1+TIMEOUT.
- A match in the last SETTLE cycle counts as success.
- After the RESP handshake, cmd_ready rises the next cycle. There is one mandatory bubble; a command is never accepted in the handshake cycle.
- Back-to-back commands of opposite polarity are separated by at least 1 (RESP) + 1 (IDLE) cycles with S=R=0.

## Configuration
- SR_DRV_SKIP_EN defined:
  - In IDLE, an accepted command whose target already matches q_s/qb_s goes directly to RESP with rsp_err=0.
  - rsp_valid is high at cycle 1, and S and R stay 0.
- SR_DRV_SKIP_EN undefined: every command issues a full pulse regardless of the current latch state.

## Structure
- Package sr_drv_pkg:
  - state encoding SR_IDLE, SR_PULSE, SR_SETTLE, SR_RESP (2-bit);
  - counter widths (4-bit pulse, 8-bit timeout);
  - synchroniser reset constants Q_RST=0, QBAR_RST=1.
- Sub-module sr_drv_sync: a parameterless 2-bit, 2-flop synchroniser with per-bit reset values, instantiated once for {Q, Qbar}.
- Top: FSM, pulse/timeout counters, response registers.

## Test plan
- Reset behaviour: release reset -> S=0, R=0, cmd_ready=1, rsp_valid=0; q_s=0 and qb_s=1 until the synchroniser fills.
- Set, behavioural latch model, PULSE_W=2: cmd_set=1 at cycle 0 -> S=1 in cycles 1-2, R=0 throughout, rsp_valid at cycle 4, rsp_err=0, rsp_q=1.
- Stuck latch, TIMEOUT=8: Q held at 0, cmd_set=1 -> rsp_valid at cycle 11, rsp_err=1, rsp_q=0.
- Backpressure: rsp_ready held low 5 cycles -> rsp_valid, rsp_err and rsp_q stable; cmd_ready=0; cmd_valid pulses ignored; after the handshake, cmd_ready=1 one cycle later.
- Reset mid-operation: reset_n asserted during PULSE -> S falls in the same cycle without waiting for a clock edge; after release the block is in IDLE and no rsp_valid appears.
- SR_DRV_SKIP_EN defined, Q=1: cmd_set=1 -> rsp_valid at cycle 1, rsp_err=0, S never asserted. Then cmd_set=0 -> full R pulse issued.

Source files
------------

// File: rtl/sr_latch_driver_pkg.sv
// Shared types and constants for the SR latch command driver.
package sr_drv_pkg;

  typedef enum logic [1:0] {
    SR_IDLE   = 2'd0,
    SR_PULSE  = 2'd1,
    SR_SETTLE = 2'd2,
    SR_RESP   = 2'd3
  } sr_state_t;

  localparam int PULSE_CNT_W = 4;
  localparam int TMO_CNT_W   = 8;

  localparam logic Q_RST    = 1'b0;
  localparam logic QBAR_RST = 1'b1;

  // Feedback agrees with the target only when both rails are consistent with it.
  function automatic logic fb_match(input logic q_s, input logic qb_s, input logic target);
    return (q_s == target) && (qb_s == ~target);
  endfunction

endpackage

// File: rtl/sr_latch_driver_if.sv
// Command/response handshake bundle between control logic and sr_latch_driver.
interface sr_latch_driver_if;
  logic cmd_valid;
  logic cmd_ready;
  logic cmd_set;
  logic rsp_valid;
  logic rsp_ready;
  logic rsp_err;
  logic rsp_q;

  modport master (
    output cmd_valid, cmd_set, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_err, rsp_q
  );

  modport slave (
    input  cmd_valid, cmd_set, rsp_ready,
    output cmd_ready, rsp_valid, rsp_err, rsp_q
  );
endinterface

// File: rtl/sr_latch_driver_sync.sv
// Two-flop synchroniser for the latch feedback pair; bit 1 = Q, bit 0 = Qbar,
// each bit resetting to its own idle level.
module sr_drv_sync
  import sr_drv_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] d,
  output logic [1:0] q
);

  localparam logic [1:0] RST_VAL = {Q_RST, QBAR_RST};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bit
      logic meta_reg;
      logic sync_reg;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          meta_reg <= RST_VAL[gi];
          sync_reg <= RST_VAL[gi];
        end else begin
          meta_reg <= d[gi];
          sync_reg <= meta_reg;
        end
      end

      assign q[gi] = sync_reg;
    end
  endgenerate

endmodule

// File: rtl/sr_latch_driver.sv
// Clocked controller for an asynchronous SR latch: pulses S/R on command,
// waits for synchronised feedback, returns pass/fail. Optional SR_DRV_SKIP_EN
// short-circuits commands whose target the latch already holds.
module sr_latch_driver
  import sr_drv_pkg::*;
#(
  parameter int PULSE_W = 2,
  parameter int TIMEOUT = 8
)
(
  input  logic               clock,
  input  logic               reset_n,
  sr_latch_driver_if.slave   bus,
  output logic               S,
  output logic               R,
  input  logic               Q,
  input  logic               Qbar
);

  localparam logic [PULSE_CNT_W-1:0] PULSE_LAST = PULSE_CNT_W'(PULSE_W - 1);
  localparam logic [TMO_CNT_W-1:0]   TMO_LAST   = TMO_CNT_W'(TIMEOUT - 1);

  sr_state_t              state_reg, state_next;
  logic                   target_reg, target_next;
  logic [PULSE_CNT_W-1:0] pulse_cnt_reg, pulse_cnt_next;
  logic [TMO_CNT_W-1:0]   tmo_cnt_reg, tmo_cnt_next;
  logic                   s_reg, s_next;
  logic                   r_reg, r_next;
  logic                   rsp_err_reg, rsp_err_next;
  logic                   rsp_q_reg, rsp_q_next;

  logic [1:0] fb_sync;
  logic       q_s;
  logic       qb_s;

  sr_drv_sync u_sync (
    .clock   (clock),
    .reset_n (reset_n),
    .d       ({Q, Qbar}),
    .q       (fb_sync)
  );

  assign q_s  = fb_sync[1];
  assign qb_s = fb_sync[0];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= SR_IDLE;
      target_reg    <= 1'b0;
      pulse_cnt_reg <= '0;
      tmo_cnt_reg   <= '0;
      s_reg         <= 1'b0;
      r_reg         <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_q_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      target_reg    <= target_next;
      pulse_cnt_reg <= pulse_cnt_next;
      tmo_cnt_reg   <= tmo_cnt_next;
      s_reg         <= s_next;
      r_reg         <= r_next;
      rsp_err_reg   <= rsp_err_next;
      rsp_q_reg     <= rsp_q_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    target_next    = target_reg;
    pulse_cnt_next = pulse_cnt_reg;
    tmo_cnt_next   = tmo_cnt_reg;
    rsp_err_next   = rsp_err_reg;
    rsp_q_next     = rsp_q_reg;

    case (state_reg)
      SR_IDLE: begin
        if (bus.cmd_valid) begin
          target_next    = bus.cmd_set;
          pulse_cnt_next = '0;
`ifdef SR_DRV_SKIP_EN
          if (fb_match(q_s, qb_s, bus.cmd_set)) begin
            state_next   = SR_RESP;
            rsp_err_next = 1'b0;
            rsp_q_next   = q_s;
          end else begin
            state_next   = SR_PULSE;
          end
`else
          state_next = SR_PULSE;
`endif
        end
      end

      SR_PULSE: begin
        if (pulse_cnt_reg == PULSE_LAST) begin
          state_next   = SR_SETTLE;
          tmo_cnt_next = '0;
        end else begin
          pulse_cnt_next = pulse_cnt_reg + 1'b1;
        end
      end

      SR_SETTLE: begin
        // A match on the final cycle wins over the timeout.
        if (fb_match(q_s, qb_s, target_reg)) begin
          state_next   = SR_RESP;
          rsp_err_next = 1'b0;
          rsp_q_next   = q_s;
        end else if (tmo_cnt_reg == TMO_LAST) begin
          state_next   = SR_RESP;
          rsp_err_next = 1'b1;
          rsp_q_next   = q_s;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + 1'b1;
        end
      end

      SR_RESP: begin
        if (bus.rsp_ready) begin
          state_next = SR_IDLE;
        end
      end

      default: begin
        state_next = SR_IDLE;
      end
    endcase

    // Drives come straight from flops so the latch never sees decode glitches.
    s_next = (state_next == SR_PULSE) &&  target_next;
    r_next = (state_next == SR_PULSE) && !target_next;
  end

  assign S             = s_reg;
  assign R             = r_reg;
  assign bus.cmd_ready = (state_reg == SR_IDLE);
  assign bus.rsp_valid = (state_reg == SR_RESP);
  assign bus.rsp_err   = rsp_err_reg;
  assign bus.rsp_q     = rsp_q_reg;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed self-checking bench for sr_latch_driver (PULSE_W=2, TIMEOUT=8) with
// a behavioural SR latch that can be overridden to model stuck feedback.
module tb_sr_latch_driver;
  import sr_drv_pkg::*;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic S, R, Q, Qbar;

  logic lat_q = 1'b0;
  logic force_en = 1'b0;
  logic force_q = 1'b0;
  logic force_qb = 1'b1;

  int n_cmp = 0;
  int n_err = 0;

  sr_latch_driver_if bus();

  sr_latch_driver #(.PULSE_W(2), .TIMEOUT(8)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus),
    .S       (S),
    .R       (R),
    .Q       (Q),
    .Qbar    (Qbar)
  );

  always #5 clock = ~clock;

  always @(S or R) begin
    if (S && !R) lat_q = 1'b1;
    else if (R && !S) lat_q = 1'b0;
  end

  assign Q    = force_en ? force_q  : lat_q;
  assign Qbar = force_en ? force_qb : ~lat_q;

  always @(negedge clock) begin
    n_cmp++;
    assert (!(S && R)) else begin
      n_err++;
      $error("FAIL s_and_r: observed S=%b R=%b required not both 1", S, R);
    end
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b required %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Leaves the bench in cycle 1 (just after the acceptance edge).
  task automatic accept(input logic set);
    bus.cmd_valid = 1'b1;
    bus.cmd_set   = set;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic handshake();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no end of test, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_set   = 1'b0;
    bus.rsp_ready = 1'b0;
    force_en = 1'b1;
    force_q  = 1'b1;
    force_qb = 1'b0;

    // Reset state, with feedback opposite to the synchroniser reset values
    ticks(2);
    chk("rst_S", S, 1'b0);
    chk("rst_R", R, 1'b0);
    chk("rst_cmd_ready", bus.cmd_ready, 1'b1);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_err", bus.rsp_err, 1'b0);
    chk("rst_rsp_q", bus.rsp_q, 1'b0);
    chk("rst_q_s", dut.q_s, 1'b0);
    chk("rst_qb_s", dut.qb_s, 1'b1);
    reset_n = 1'b1;
    tick();
    chk("fill1_q_s", dut.q_s, 1'b0);
    chk("fill1_qb_s", dut.qb_s, 1'b1);
    tick();
    chk("fill2_q_s", dut.q_s, 1'b1);
    chk("fill2_qb_s", dut.qb_s, 1'b0);
    force_q  = 1'b0;
    force_qb = 1'b1;
    ticks(3);
    force_en = 1'b0;

    // Set command with a responsive latch
    accept(1'b1);
    chk("set_c1_S", S, 1'b1);
    chk("set_c1_R", R, 1'b0);
    chk("set_c1_cmd_ready", bus.cmd_ready, 1'b0);
    tick();
    chk("set_c2_S", S, 1'b1);
    tick();
    chk("set_c3_S", S, 1'b0);
    chk("set_c3_rsp_valid", bus.rsp_valid, 1'b0);
    tick();
    chk("set_c4_rsp_valid", bus.rsp_valid, 1'b1);
    chk("set_c4_rsp_err", bus.rsp_err, 1'b0);
    chk("set_c4_rsp_q", bus.rsp_q, 1'b1);
    handshake();
    chk("set_hs_cmd_ready", bus.cmd_ready, 1'b1);
    chk("set_hs_rsp_valid", bus.rsp_valid, 1'b0);

    // Reset command, then backpressure on the response
    accept(1'b0);
    chk("clr_c1_R", R, 1'b1);
    chk("clr_c1_S", S, 1'b0);
    ticks(2);
    chk("clr_c3_R", R, 1'b0);
    tick();
    chk("clr_c4_rsp_valid", bus.rsp_valid, 1'b1);
    chk("clr_c4_rsp_q", bus.rsp_q, 1'b0);
    for (int i = 0; i < 5; i++) begin
      bus.cmd_valid = i[0];
      bus.cmd_set   = 1'b1;
      tick();
      chk("bp_rsp_valid", bus.rsp_valid, 1'b1);
      chk("bp_rsp_err", bus.rsp_err, 1'b0);
      chk("bp_rsp_q", bus.rsp_q, 1'b0);
      chk("bp_cmd_ready", bus.cmd_ready, 1'b0);
      chk("bp_S", S, 1'b0);
    end
    bus.cmd_valid = 1'b1;
    handshake();
    bus.cmd_valid = 1'b0;
    chk("bp_hs_cmd_ready", bus.cmd_ready, 1'b1);
    chk("bp_hs_S", S, 1'b0);
    tick();
    chk("bp_idle_S", S, 1'b0);
    chk("bp_idle_rsp_valid", bus.rsp_valid, 1'b0);

    // Stuck latch: feedback held at Q=0
    force_en = 1'b1;
    force_q  = 1'b0;
    force_qb = 1'b1;
    accept(1'b1);
    ticks(9);
    chk("stuck_c10_rsp_valid", bus.rsp_valid, 1'b0);
    tick();
    chk("stuck_c11_rsp_valid", bus.rsp_valid, 1'b1);
    chk("stuck_c11_rsp_err", bus.rsp_err, 1'b1);
    chk("stuck_c11_rsp_q", bus.rsp_q, 1'b0);
    handshake();

    // Q == Qbar never matches
    force_q  = 1'b1;
    force_qb = 1'b1;
    accept(1'b1);
    ticks(10);
    chk("eq_c11_rsp_valid", bus.rsp_valid, 1'b1);
    chk("eq_c11_rsp_err", bus.rsp_err, 1'b1);
    chk("eq_c11_rsp_q", bus.rsp_q, 1'b1);
    handshake();

    // Feedback arrives in the last SETTLE cycle (cycle 10)
    force_q  = 1'b1;
    force_qb = 1'b0;
    ticks(3);
    accept(1'b0);
    ticks(7);
    force_q  = 1'b0;
    force_qb = 1'b1;
    ticks(2);
    chk("last_c10_rsp_valid", bus.rsp_valid, 1'b0);
    tick();
    chk("last_c11_rsp_valid", bus.rsp_valid, 1'b1);
    chk("last_c11_rsp_err", bus.rsp_err, 1'b0);
    chk("last_c11_rsp_q", bus.rsp_q, 1'b0);
    handshake();
    force_en = 1'b0;
    ticks(3);

    // Reset asserted during PULSE
    accept(1'b1);
    chk("mid_c1_S", S, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_async_S", S, 1'b0);
    chk("mid_async_cmd_ready", bus.cmd_ready, 1'b1);
    #10;
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("mid_after_rsp_valid", bus.rsp_valid, 1'b0);
      chk("mid_after_cmd_ready", bus.cmd_ready, 1'b1);
      chk("mid_after_S", S, 1'b0);
    end

    // Latch already set (Q=1) and another set command arrives
    chk("pre_skip_q_s", dut.q_s, 1'b1);
`ifdef SR_DRV_SKIP_EN
    accept(1'b1);
    chk("skip_c1_rsp_valid", bus.rsp_valid, 1'b1);
    chk("skip_c1_rsp_err", bus.rsp_err, 1'b0);
    chk("skip_c1_rsp_q", bus.rsp_q, 1'b1);
    chk("skip_c1_S", S, 1'b0);
    handshake();
    chk("skip_hs_S", S, 1'b0);
    accept(1'b0);
    chk("skip_clr_c1_R", R, 1'b1);
    ticks(3);
    chk("skip_clr_c4_rsp_valid", bus.rsp_valid, 1'b1);
    chk("skip_clr_c4_rsp_q", bus.rsp_q, 1'b0);
    handshake();
`else
    accept(1'b1);
    chk("noskip_c1_S", S, 1'b1);
    chk("noskip_c1_rsp_valid", bus.rsp_valid, 1'b0);
    ticks(3);
    chk("noskip_c4_rsp_valid", bus.rsp_valid, 1'b1);
    chk("noskip_c4_rsp_q", bus.rsp_q, 1'b1);
    handshake();
`endif
    chk("end_cmd_ready", bus.cmd_ready, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
